// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/EX hazard signals between the pipeline and the hazard controller
interface hazard_ctrl_if #(
    parameter int RA_BITS  = 5,
    parameter int CNT_BITS = 16
);
    logic [RA_BITS-1:0]  D_ra;
    logic [RA_BITS-1:0]  D_rb;
    logic [RA_BITS-1:0]  D_rd;
    logic                D_we;
    logic                D_ld;
    logic                EX_taken;
    logic                F_stall;
    logic                D_stall;
    logic                D_flush;
    logic                EX_bubble;
    logic [1:0]          EX_fwd_a;
    logic [1:0]          EX_fwd_b;
    logic [CNT_BITS-1:0] stall_cnt;
    logic [CNT_BITS-1:0] flush_cnt;
    modport master (
        output D_ra, D_rb, D_rd, D_we, D_ld, EX_taken,
        input  F_stall, D_stall, D_flush, EX_bubble, EX_fwd_a, EX_fwd_b, stall_cnt, flush_cnt
    );
    modport slave (
        input  D_ra, D_rb, D_rd, D_we, D_ld, EX_taken,
        output F_stall, D_stall, D_flush, EX_bubble, EX_fwd_a, EX_fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush, EX forwarding selects and event counters
module hazard_ctrl #(
    parameter int XLEN            = 32,
    parameter int RA_BITS         = 5,
    parameter int CNT_BITS        = 16,
    parameter int ZERO_REG_EXEMPT = 1
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic               v;
        logic               we;
        logic               ld;
        logic [RA_BITS-1:0] rd;
    } sh_t;

    sh_t        sh_ex, sh_mem;
    logic       lu;
    logic [1:0] fa, fb;

    function automatic logic match(input logic [RA_BITS-1:0] x, input sh_t e);
        return e.v & e.we & (e.rd == x) & !(ZERO_REG_EXEMPT != 0 && e.rd == '0);
    endfunction

    // hazard detection and next forwarding selects; MEM-stage ALU result has priority
    always_comb begin
        lu = sh_ex.ld & (match(bus.D_ra, sh_ex) | match(bus.D_rb, sh_ex));
        fa = (match(bus.D_ra, sh_ex) & !sh_ex.ld) ? 2'b01 : match(bus.D_ra, sh_mem) ? 2'b10 : 2'b00;
        fb = (match(bus.D_rb, sh_ex) & !sh_ex.ld) ? 2'b01 : match(bus.D_rb, sh_mem) ? 2'b10 : 2'b00;
    end

    assign bus.D_flush   = !rst & bus.EX_taken;
    assign bus.F_stall   = !rst & !bus.EX_taken & lu;
    assign bus.D_stall   = bus.F_stall;
    assign bus.EX_bubble = bus.D_flush | bus.F_stall;

    // shadow pipe shift, registered forward selects and saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_ex         <= '0;
            sh_mem        <= '0;
            bus.EX_fwd_a  <= 2'b00;
            bus.EX_fwd_b  <= 2'b00;
            bus.stall_cnt <= '0;
            bus.flush_cnt <= '0;
        end else begin
            sh_mem       <= sh_ex;
            sh_ex        <= bus.EX_bubble ? sh_t'('0) : sh_t'{v: 1'b1, we: bus.D_we, ld: bus.D_ld, rd: bus.D_rd};
            bus.EX_fwd_a <= bus.EX_bubble ? 2'b00 : fa;
            bus.EX_fwd_b <= bus.EX_bubble ? 2'b00 : fb;
            if (bus.F_stall && !(&bus.stall_cnt))
                bus.stall_cnt <= bus.stall_cnt + 1'b1;
            if (bus.D_flush && !(&bus.flush_cnt))
                bus.flush_cnt <= bus.flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against an issue-history model
module tb_hazard_ctrl;
    localparam int N = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.RA_BITS(5), .CNT_BITS(16)) bus ();
    hazard_ctrl_if #(.RA_BITS(5), .CNT_BITS(4))  bus4 ();

    hazard_ctrl #(.XLEN(32), .RA_BITS(5), .CNT_BITS(16), .ZERO_REG_EXEMPT(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    hazard_ctrl #(.XLEN(32), .RA_BITS(5), .CNT_BITS(4), .ZERO_REG_EXEMPT(1)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    assign bus4.D_ra     = bus.D_ra;
    assign bus4.D_rb     = bus.D_rb;
    assign bus4.D_rd     = bus.D_rd;
    assign bus4.D_we     = bus.D_we;
    assign bus4.D_ld     = bus.D_ld;
    assign bus4.EX_taken = bus.EX_taken;

    // issue history: what entered EX in each cycle (iss=0 means a bubble or reset)
    bit         rst_h [N];
    bit         iss   [N];
    bit         we_h  [N];
    bit         ld_h  [N];
    logic [4:0] rd_h  [N];
    logic [4:0] ra_h  [N];
    logic [4:0] rb_h  [N];

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;
    int m_stall = 0, m_flush = 0, m_stall4 = 0, m_flush4 = 0;

    // producer issued in cycle j still visible at cycle now and writing register x
    function automatic bit hit(logic [4:0] x, int j, int now);
        if (j < 0) return 0;
        if (!iss[j] || !we_h[j] || rd_h[j] != x || rd_h[j] == 5'd0) return 0;
        for (int k = j + 1; k < now; k++)
            if (rst_h[k]) return 0;
        return 1;
    endfunction

    function automatic logic [1:0] src(logic [4:0] x, int p);
        if (hit(x, p - 1, p) && !ld_h[p - 1]) return 2'b01;
        if (hit(x, p - 2, p)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(bit r, logic [4:0] ra, logic [4:0] rb, logic [4:0] rd, bit we, bit ld, bit tk);
        bit lu, e_flush, e_stall;
        logic [1:0] e_fa, e_fb;
        @(negedge clk);
        rst = r;
        bus.D_ra = ra; bus.D_rb = rb; bus.D_rd = rd;
        bus.D_we = we; bus.D_ld = ld; bus.EX_taken = tk;
        #1;
        lu = 0;
        if (hit(ra, cyc - 1, cyc) || hit(rb, cyc - 1, cyc)) lu = ld_h[cyc - 1];
        e_flush = !r && tk;
        e_stall = !r && !tk && lu;
        chk("F_stall", 32'(bus.F_stall), 32'(e_stall));
        chk("D_stall", 32'(bus.D_stall), 32'(e_stall));
        chk("D_flush", 32'(bus.D_flush), 32'(e_flush));
        chk("EX_bubble", 32'(bus.EX_bubble), 32'(e_flush | e_stall));
        if (cyc > 0) begin
            e_fa = iss[cyc - 1] ? src(ra_h[cyc - 1], cyc - 1) : 2'b00;
            e_fb = iss[cyc - 1] ? src(rb_h[cyc - 1], cyc - 1) : 2'b00;
            chk("EX_fwd_a", 32'(bus.EX_fwd_a), 32'(e_fa));
            chk("EX_fwd_b", 32'(bus.EX_fwd_b), 32'(e_fb));
            chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
            chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
            chk("stall_cnt4", 32'(bus4.stall_cnt), 32'(m_stall4));
            chk("flush_cnt4", 32'(bus4.flush_cnt), 32'(m_flush4));
        end
        rst_h[cyc] = r;
        iss[cyc]   = !r && !(e_flush || e_stall);
        we_h[cyc] = we; ld_h[cyc] = ld; rd_h[cyc] = rd; ra_h[cyc] = ra; rb_h[cyc] = rb;
        @(posedge clk);
        if (r) begin
            m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
        end else begin
            if (e_stall) begin
                m_stall  = (m_stall == 65535) ? m_stall : m_stall + 1;
                m_stall4 = (m_stall4 == 15) ? m_stall4 : m_stall4 + 1;
            end
            if (e_flush) begin
                m_flush  = (m_flush == 65535) ? m_flush : m_flush + 1;
                m_flush4 = (m_flush4 == 15) ? m_flush4 : m_flush4 + 1;
            end
        end
        cyc++;
    endtask

    initial begin
        bus.D_ra = '0; bus.D_rb = '0; bus.D_rd = '0;
        bus.D_we = 1'b0; bus.D_ld = 1'b0; bus.EX_taken = 1'b0;
        // reset held two cycles with loads writing on all inputs
        step(1, 5'd1, 5'd2, 5'd1, 1, 1, 0);
        step(1, 5'd1, 5'd2, 5'd1, 1, 1, 0);
        step(0, 5'd1, 5'd2, 5'd0, 0, 0, 0);
        #1;
        chk("reset_fwd_a", 32'(bus.EX_fwd_a), 32'd0);
        chk("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        // back-to-back ALU, then distance 2 and 3
        step(0, 5'd0, 5'd0, 5'd3, 1, 0, 0);
        step(0, 5'd3, 5'd0, 5'd4, 1, 0, 0);
        #1 chk("alu_dist1", 32'(bus.EX_fwd_a), 32'd1);
        step(0, 5'd0, 5'd0, 5'd3, 1, 0, 0);
        step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 5'd3, 5'd0, 5'd4, 1, 0, 0);
        #1 chk("alu_dist2", 32'(bus.EX_fwd_a), 32'd2);
        step(0, 5'd0, 5'd0, 5'd3, 1, 0, 0);
        step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 5'd3, 5'd0, 5'd4, 1, 0, 0);
        #1 chk("alu_dist3", 32'(bus.EX_fwd_a), 32'd0);
        // load-use on operand B: one stall, then WB forwarding
        step(0, 5'd0, 5'd0, 5'd5, 1, 1, 0);
        step(0, 5'd1, 5'd5, 5'd6, 1, 0, 0);
        #1 chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
        step(0, 5'd1, 5'd5, 5'd6, 1, 0, 0);
        #1 chk("lu_fwd_b", 32'(bus.EX_fwd_b), 32'd2);
        // same load feeding both operands still costs one cycle
        step(0, 5'd0, 5'd0, 5'd6, 1, 1, 0);
        step(0, 5'd6, 5'd6, 5'd7, 1, 0, 0);
        step(0, 5'd6, 5'd6, 5'd7, 1, 0, 0);
        #1 chk("lu_both_cnt", 32'(bus.stall_cnt), 32'd2);
        // register 0 never stalls or forwards
        step(0, 5'd0, 5'd0, 5'd0, 1, 1, 0);
        step(0, 5'd0, 5'd0, 5'd1, 1, 0, 0);
        #1 chk("r0_fwd_a", 32'(bus.EX_fwd_a), 32'd0);
        // taken branch, alone and together with a load-use
        step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        #1 chk("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        step(0, 5'd0, 5'd0, 5'd7, 1, 1, 0);
        step(0, 5'd7, 5'd0, 5'd1, 1, 0, 1);
        #1 chk("br_lu_stall_cnt", 32'(bus.stall_cnt), 32'd2);
        // reset during a load-use stall
        step(0, 5'd0, 5'd0, 5'd8, 1, 1, 0);
        step(1, 5'd8, 5'd0, 5'd1, 1, 0, 0);
        step(0, 5'd8, 5'd0, 5'd1, 1, 0, 0);
        // saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            step(0, 5'd0, 5'd0, 5'd1, 1, 1, 0);
            step(0, 5'd1, 5'd2, 5'd2, 1, 0, 0);
            step(0, 5'd1, 5'd2, 5'd2, 1, 0, 0);
        end
        #1 chk("sat_stall_cnt4", 32'(bus4.stall_cnt), 32'd15);
        // randomized traffic over a small register set
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 63) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
